rs485_frame_rx: RTL and testbench

//  Frame parser directly downstream of the RS485 UART top. Consumes its 1-cycle rx_ready strobe + rx_data byte,

---
 rtl/rs485_frame_rx_pkg.sv | 22 ++
 rtl/rs485_frame_rx_if.sv | 28 ++
 rtl/rs485_frame_rx_byte_timer.sv | 33 +++
 rtl/rs485_frame_rx.sv | 150 +++++++++++++++
 tb/tb_rs485_frame_rx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rs485_frame_rx_pkg.sv
// Shared encodings for the RS485 frame receiver: FSM states, error codes, default marker bytes.
package rs485_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CSUM = 2'b01,
        ERR_LEN  = 2'b10,
        ERR_TMO  = 2'b11
    } err_e;

    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] DEF_BCAST_ADDR = 8'hFF;

endpackage

// File: rtl/rs485_frame_rx_if.sv
// Byte-in / payload-write / status bundle between the UART top, the frame parser and its consumer.
interface rs485_frame_rx_if #(
    parameter int AW = 5
);
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic [7:0]    my_addr;
    logic          pl_wr_en;
    logic [AW-1:0] pl_wr_addr;
    logic [7:0]    pl_wr_data;
    logic          frame_done;
    logic [7:0]    frame_len;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          busy;

    modport slave (
        input  rx_ready, rx_data, my_addr,
        output pl_wr_en, pl_wr_addr, pl_wr_data, frame_done, frame_len,
               frame_err, err_code, busy
    );

    modport master (
        output rx_ready, rx_data, my_addr,
        input  pl_wr_en, pl_wr_addr, pl_wr_data, frame_done, frame_len,
               frame_err, err_code, busy
    );
endinterface

// File: rtl/rs485_frame_rx_byte_timer.sv
// Inter-byte watchdog: cleared by each received byte, counts while enabled, pulses expire on the
// last cycle before TIMEOUT_CYC idle cycles have elapsed so the error registers exactly at the limit.
module rs485_byte_timer #(
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en)
            cnt_d = '0;
        else if (cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A byte arriving on the expiry cycle takes priority, so clr masks the pulse.
    assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/rs485_frame_rx.sv
// Frame parser [SYNC][ADDR][LEN][PAYLOAD x LEN][CSUM]: address filter, speculative payload writes,
// done/error pulses. All responses are registered one cycle after the causing rx_ready.
module rs485_frame_rx
    import rs485_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter logic [7:0] BCAST_ADDR  = DEF_BCAST_ADDR,
    parameter int         MAX_LEN     = 32,
    parameter int         AW          = 5,
    parameter int         TIMEOUT_CYC = 2000
) (
    input logic            clk,
    input logic            rst_n,
    rs485_frame_rx_if.slave bus
);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e        state_q, state_d;
    logic          match_q, match_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    len_q, len_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic [7:0]    flen_q, flen_d;
    logic          err_q, err_d;
    err_e          ecode_q, ecode_d;
    logic          busy, tmo;
    logic [7:0]    rx_byte;

    assign busy    = (state_q != ST_IDLE);
    assign rx_byte = bus.rx_data;

    rs485_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.rx_ready),
        .en     (busy),
        .expire (tmo)
    );

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        sum_d     = sum_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        flen_d    = flen_q;
        err_d     = 1'b0;
        ecode_d   = ecode_q;
        if (bus.rx_ready) begin
            unique case (state_q)
                ST_IDLE: if (rx_byte == SYNC_BYTE) state_d = ST_ADDR;
                ST_ADDR: begin
                    match_d = (rx_byte == bus.my_addr) || (rx_byte == BCAST_ADDR);
                    sum_d   = rx_byte;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    sum_d = sum_q + rx_byte;
                    len_d = rx_byte;
                    // Over-length is reported even for foreign frames: we lose alignment either way.
                    if (rx_byte > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        ecode_d = ERR_LEN;
                        state_d = ST_IDLE;
                    end else if (rx_byte == 8'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    sum_d = sum_q + rx_byte;
                    if (match_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q;
                        wr_data_d = rx_byte;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (8'(cnt_q) == len_q - 8'd1) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (match_q) begin
                        if (rx_byte == sum_q) begin
                            done_d = 1'b1;
                            flen_d = len_q;
                        end else begin
                            err_d   = 1'b1;
                            ecode_d = ERR_CSUM;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo) begin
            err_d   = 1'b1;
            ecode_d = ERR_TMO;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            match_q   <= 1'b0;
            sum_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            flen_q    <= '0;
            err_q     <= 1'b0;
            ecode_q   <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            flen_q    <= flen_d;
            err_q     <= err_d;
            ecode_q   <= ecode_d;
        end
    end

    assign bus.pl_wr_en   = wr_en_q;
    assign bus.pl_wr_addr = wr_addr_q;
    assign bus.pl_wr_data = wr_data_q;
    assign bus.frame_done = done_q;
    assign bus.frame_len  = flen_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = ecode_q;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_rs485_frame_rx.sv
// Table-driven frames plus hand sequences (timeout, expiry race, mid-frame reset); a negedge
// monitor pops expected writes and done/err events from scoreboard queues.
module tb_rs485_frame_rx;
    localparam int AW  = 5;
    localparam int MAXL = 32;
    localparam int TMO = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs485_frame_rx_if #(.AW(AW)) bus ();

    rs485_frame_rx #(
        .SYNC_BYTE(8'hA5), .BCAST_ADDR(8'hFF), .MAX_LEN(MAXL), .AW(AW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic is_err; logic [7:0] len; logic [1:0] code; } ev_t;
    typedef struct {
        logic [7:0]       my;
        int               n;
        logic [39:0][7:0] b;
        int               p0;
        int               nwr;
        int               ev;     // 0 none, 1 done, 2 err
        logic [7:0]       len;
        logic [1:0]       code;
        int               gap;
    } vec_t;

    wr_t wr_q[$];
    ev_t ev_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t w;
        ev_t e;
        if (rst_n) begin
            if (bus.pl_wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.pl_wr_addr, bus.pl_wr_data);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(bus.pl_wr_addr), 32'(w.a));
                    chk("wr_data", 32'(bus.pl_wr_data), 32'(w.d));
                end
            end
            if (bus.frame_done || bus.frame_err) begin
                chk("done_err_exclusive", 32'(bus.frame_done & bus.frame_err), 32'd0);
                if (ev_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", bus.frame_done, bus.frame_err);
                end else begin
                    e = ev_q.pop_front();
                    chk("pulse_kind_err", 32'(bus.frame_err), 32'(e.is_err));
                    if (e.is_err) chk("err_code", 32'(bus.err_code), 32'(e.code));
                    else          chk("frame_len", 32'(bus.frame_len), 32'(e.len));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic drained(input string nm);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_wr_left"}, 32'(wr_q.size()), 32'd0);
        chk({nm, "_ev_left"}, 32'(ev_q.size()), 32'd0);
        wr_q.delete();
        ev_q.delete();
    endtask

    task automatic apply(input vec_t t);
        bus.my_addr = t.my;
        for (int k = 0; k < t.n; k++) begin
            if (k >= t.p0 && k < t.p0 + t.nwr)
                wr_q.push_back('{a: AW'(k - t.p0), d: t.b[k]});
            if (k == t.n - 1 && t.ev != 0)
                ev_q.push_back('{is_err: (t.ev == 2), len: t.len, code: t.code});
            send(t.b[k]);
            if (t.gap > 0 && k < t.n - 1) idle(t.gap);
        end
        idle(3);
        drained("vec");
        if (t.ev == 1) chk("frame_len_held", 32'(bus.frame_len), 32'(t.len));
        if (t.ev == 2) chk("err_code_held", 32'(bus.err_code), 32'(t.code));
    endtask

    function automatic vec_t mk(input logic [7:0] my, input int n, input logic [0:7][7:0] bs,
                                input int p0, input int nwr, input int ev,
                                input logic [7:0] len, input logic [1:0] code, input int gap);
        vec_t t;
        t.my = my; t.n = n; t.p0 = p0; t.nwr = nwr; t.ev = ev;
        t.len = len; t.code = code; t.gap = gap;
        t.b = '0;
        for (int k = 0; k < 8; k++) t.b[k] = bs[k];
        return t;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t v[11];

    initial begin : stim
        logic [7:0] s;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.my_addr  = 8'h03;

        // Checksum = ADDR + LEN + payload, modulo 256.
        v[0]  = mk(8'h03, 6, {8'hA5,8'h03,8'h02,8'h11,8'h22,8'h38,8'h00,8'h00}, 3, 2, 1, 8'd2, 2'b00, 0);
        v[1]  = mk(8'h03, 6, {8'hA5,8'h03,8'h02,8'h11,8'h22,8'h37,8'h00,8'h00}, 3, 2, 2, 8'd0, 2'b01, 1);
        v[2]  = mk(8'h03, 3, {8'hA5,8'h03,8'h21,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 2, 8'd0, 2'b10, 0);
        v[3]  = mk(8'h03, 5, {8'hA5,8'h03,8'h01,8'h7E,8'h82,8'h00,8'h00,8'h00}, 3, 1, 1, 8'd1, 2'b00, 0);
        v[4]  = mk(8'h03, 4, {8'hA5,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00}, 3, 0, 1, 8'd0, 2'b00, 0);
        v[5]  = mk(8'h03, 5, {8'hA5,8'h07,8'h01,8'h55,8'h5D,8'h00,8'h00,8'h00}, 3, 0, 0, 8'd0, 2'b00, 0);
        v[6]  = mk(8'h03, 6, {8'h12,8'hA5,8'h03,8'h01,8'hA5,8'hA9,8'h00,8'h00}, 4, 1, 1, 8'd1, 2'b00, 2);
        v[7]  = mk(8'h07, 5, {8'hA5,8'h07,8'h01,8'h55,8'h5D,8'h00,8'h00,8'h00}, 3, 1, 1, 8'd1, 2'b00, 0);
        v[8]  = mk(8'h03, 36, {8'hA5,8'h03,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 32, 1, 8'd32, 2'b00, 0);
        v[9]  = mk(8'h03, 3, {8'hA5,8'h44,8'h21,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 2, 8'd0, 2'b10, 0);
        v[10] = mk(8'h03, 5, {8'hA5,8'h07,8'h01,8'h55,8'h00,8'h00,8'h00,8'h00}, 3, 0, 0, 8'd0, 2'b00, 0);
        s = 8'h03 + 8'h20;
        for (int i = 0; i < 32; i++) begin
            v[8].b[3 + i] = 8'(i * 7 + 1);
            s = s + v[8].b[3 + i];
        end
        v[8].b[35] = s;

        idle(3);
        @(negedge clk);
        chk("rst_wr_en", 32'(bus.pl_wr_en), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_err", 32'(bus.frame_err), 32'd0);
        chk("rst_len", 32'(bus.frame_len), 32'd0);
        chk("rst_code", 32'(bus.err_code), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        foreach (v[i]) apply(v[i]);

        // Silence after ADDR: error lands exactly TMO idle cycles after the last byte.
        bus.my_addr = 8'h03;
        send(8'hA5);
        send(8'h03);
        idle(TMO - 1);
        chk("tmo_not_early_busy", 32'(bus.busy), 32'd1);
        chk("tmo_not_early_err", 32'(bus.frame_err), 32'd0);
        ev_q.push_back('{is_err: 1'b1, len: 8'd0, code: 2'b11});
        idle(1);
        chk("tmo_busy_cleared", 32'(bus.busy), 32'd0);
        chk("tmo_err_pulse", 32'(bus.frame_err), 32'd1);
        idle(2);
        drained("tmo");

        // A byte on the expiry cycle wins and the frame completes.
        send(8'hA5);
        send(8'h03);
        send(8'h02);
        wr_q.push_back('{a: AW'(0), d: 8'h11});
        send(8'h11);
        idle(TMO - 1);
        wr_q.push_back('{a: AW'(1), d: 8'h22});
        send(8'h22);
        chk("race_no_err", 32'(bus.frame_err), 32'd0);
        ev_q.push_back('{is_err: 1'b0, len: 8'd2, code: 2'b00});
        send(8'h38);
        idle(3);
        drained("race");

        // Reset mid-DATA discards the frame silently.
        send(8'hA5);
        send(8'h03);
        send(8'h04);
        wr_q.push_back('{a: AW'(0), d: 8'h11});
        send(8'h11);
        wr_q.push_back('{a: AW'(1), d: 8'h22});
        send(8'h22);
        idle(1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_wr_en", 32'(bus.pl_wr_en), 32'd0);
        chk("mid_rst_addr", 32'(bus.pl_wr_addr), 32'd0);
        chk("mid_rst_data", 32'(bus.pl_wr_data), 32'd0);
        chk("mid_rst_len", 32'(bus.frame_len), 32'd0);
        chk("mid_rst_code", 32'(bus.err_code), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        drained("mid_rst");
        apply(v[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
